// File: rtl/rca_pipe_if.sv
// rtl/rca_pipe_if.sv - operand/result handshake bundle for rca_pipe
interface rca_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/rca_pipe.sv
// rtl/rca_pipe.sv - pipelined ripple-carry adder, one SEG-bit segment per stage
// Optional feature macro: RCA_PIPE_SAT_EN (saturate sum on signed overflow)
module rca_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic         clk,
  input  logic         rst,
  rca_pipe_if.slave    bus
);
  localparam int STAGES = WIDTH / SEG;

  logic en;
  logic out_valid_d, out_valid_q;

  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;

  // Stages 0..STAGES-2: each keeps only the operand bits not yet added and the
  // sum bits already produced, so register widths shrink/grow along the pipe.
  for (genvar k = 0; k < STAGES - 1; k++) begin : g_mid
    localparam int LO = k * SEG;
    localparam int HW = WIDTH - LO;

    logic [HW-1:0]     a_in, b_in;
    logic              c_in, v_in;
    logic [SEG:0]      seg_sum;
    logic [LO+SEG-1:0] s_acc;

    logic [HW-SEG-1:0] a_d, a_q, b_d, b_q;
    logic [LO+SEG-1:0] s_d, s_q;
    logic              c_d, c_q, v_d, v_q;

    if (k == 0) begin : g_src
      assign a_in  = bus.a;
      assign b_in  = bus.b;
      assign c_in  = bus.cin;
      assign v_in  = bus.in_valid;
      assign s_acc = seg_sum[SEG-1:0];
    end else begin : g_src
      assign a_in  = g_mid[k-1].a_q;
      assign b_in  = g_mid[k-1].b_q;
      assign c_in  = g_mid[k-1].c_q;
      assign v_in  = g_mid[k-1].v_q;
      assign s_acc = {seg_sum[SEG-1:0], g_mid[k-1].s_q};
    end

    assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

    always_comb begin
      a_d = a_q;
      b_d = b_q;
      s_d = s_q;
      c_d = c_q;
      v_d = v_q;
      if (en) begin
        a_d = a_in[HW-1:SEG];
        b_d = b_in[HW-1:SEG];
        s_d = s_acc;
        c_d = seg_sum[SEG];
        v_d = v_in;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else begin
        a_q <= a_d;
        b_q <= b_d;
        s_q <= s_d;
        c_q <= c_d;
        v_q <= v_d;
      end
    end
  end

  // Final stage: top segment, overflow detection and optional saturation.
  logic [SEG-1:0]   fin_a, fin_b;
  logic             fin_c, fin_v;
  logic [SEG:0]     fin_seg;
  logic [WIDTH-1:0] fin_raw, fin_sum;
  logic             fin_ovf;

  if (STAGES == 1) begin : g_fin_src
    assign fin_a   = bus.a;
    assign fin_b   = bus.b;
    assign fin_c   = bus.cin;
    assign fin_v   = bus.in_valid;
    assign fin_raw = fin_seg[SEG-1:0];
  end else begin : g_fin_src
    assign fin_a   = g_mid[STAGES-2].a_q;
    assign fin_b   = g_mid[STAGES-2].b_q;
    assign fin_c   = g_mid[STAGES-2].c_q;
    assign fin_v   = g_mid[STAGES-2].v_q;
    assign fin_raw = {fin_seg[SEG-1:0], g_mid[STAGES-2].s_q};
  end

  assign fin_seg = {1'b0, fin_a} + {1'b0, fin_b} + {{SEG{1'b0}}, fin_c};
  assign fin_ovf = (fin_a[SEG-1] == fin_b[SEG-1]) && (fin_seg[SEG-1] != fin_a[SEG-1]);

`ifdef RCA_PIPE_SAT_EN
  assign fin_sum = !fin_ovf     ? fin_raw :
                   fin_a[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                  {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign fin_sum = fin_raw;
`endif

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q, ovf_d, ovf_q;

  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    if (en) begin
      sum_d       = fin_sum;
      cout_d      = fin_seg[SEG];
      ovf_d       = fin_ovf;
      out_valid_d = fin_v;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_rca_pipe.sv
// tb/tb_rca_pipe.sv - randomized self-checking bench for rca_pipe (WIDTH=32, SEG=8)
module tb_rca_pipe;
  localparam int W = 32;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rca_pipe_if #(.WIDTH(W)) bus ();
  rca_pipe #(.WIDTH(W), .SEG(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int run, run_max, n_ret, base, stale;

  // Reference pipe: S slots of {cout, ovf, sum}; shifts whenever the pipe may advance.
  logic        m_v [S];
  logic [33:0] m_r [S];
  logic [31:0] xa, xb;
  logic        xc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic c);
    logic [32:0] full;
    logic        ov;
    logic [31:0] s;
    full = {1'b0, a} + {1'b0, b} + {32'd0, c};
    ov   = (a[31] == b[31]) && (full[31] != a[31]);
    s    = full[31:0];
`ifdef RCA_PIPE_SAT_EN
    if (ov) s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {full[32], ov, s};
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 7))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge: drive, check in_ready, advance model, clock, check outputs.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic ordy, input logic r);
    logic en;
    rst           = r;
    bus.in_valid  = v;
    bus.a         = a;
    bus.b         = b;
    bus.cin       = c;
    bus.out_ready = ordy;
    #1;
    en = !m_v[S-1] || ordy;
    chk("in_ready", {63'd0, bus.in_ready}, {63'd0, en});
    if (!r && bus.out_valid && ordy) n_ret++;
    if (r) begin
      for (int i = 0; i < S; i++) begin
        m_v[i] = 1'b0;
        m_r[i] = '0;
      end
    end else if (en) begin
      for (int i = S - 1; i > 0; i--) begin
        m_v[i] = m_v[i-1];
        m_r[i] = m_r[i-1];
      end
      m_v[0] = v;
      m_r[0] = ref_add(a, b, c);
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", {63'd0, bus.out_valid}, {63'd0, m_v[S-1]});
    if (m_v[S-1]) chk("result", {30'd0, bus.cout, bus.ovf, bus.sum}, {30'd0, m_r[S-1]});
    if (bus.out_valid) begin
      run++;
      if (run > run_max) run_max = run;
    end else begin
      run = 0;
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    run = 0; run_max = 0; n_ret = 0;
    for (int i = 0; i < S; i++) begin
      m_v[i] = 1'b0;
      m_r[i] = '0;
    end
    @(negedge clk);

    cycle(0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 1);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_sum", {32'd0, bus.sum}, 64'd0);
    chk("rst_cout", {63'd0, bus.cout}, 64'd0);
    chk("rst_ovf", {63'd0, bus.ovf}, 64'd0);

    // Pin the reference model against hand-computed values.
    chk("model_wrap", {30'd0, ref_add(32'h0000_0001, 32'hFFFF_FFFF, 1'b0)}, {30'd0, 2'b10, 32'h0000_0000});
    chk("model_ripple", {30'd0, ref_add(32'h00FF_FFFF, 32'h0000_0000, 1'b1)}, {30'd0, 2'b00, 32'h0100_0000});
`ifdef RCA_PIPE_SAT_EN
    chk("model_posovf", {30'd0, ref_add(32'h7FFF_FFFF, 32'h0000_0001, 1'b0)}, {30'd0, 2'b01, 32'h7FFF_FFFF});
    chk("model_negovf", {30'd0, ref_add(32'h8000_0000, 32'hFFFF_FFFF, 1'b0)}, {30'd0, 2'b11, 32'h8000_0000});
`else
    chk("model_posovf", {30'd0, ref_add(32'h7FFF_FFFF, 32'h0000_0001, 1'b0)}, {30'd0, 2'b01, 32'h8000_0000});
    chk("model_negovf", {30'd0, ref_add(32'h8000_0000, 32'hFFFF_FFFF, 1'b0)}, {30'd0, 2'b11, 32'h7FFF_FFFF});
`endif

    // Directed vectors; each emerges exactly 4 cycles after acceptance.
    cycle(1, 32'h0000_0001, 32'hFFFF_FFFF, 0, 1, 0);
    cycle(1, 32'h00FF_FFFF, 32'h0000_0000, 1, 1, 0);
    cycle(1, 32'h7FFF_FFFF, 32'h0000_0001, 0, 1, 0);
    cycle(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 0);
    chk("d0_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("d0_sum", {32'd0, bus.sum}, 64'h0);
    chk("d0_cout", {63'd0, bus.cout}, 64'd1);
    cycle(0, 0, 0, 0, 1, 0);
    chk("d1_sum", {32'd0, bus.sum}, 64'h0100_0000);
    chk("d1_cout", {63'd0, bus.cout}, 64'd0);
    cycle(0, 0, 0, 0, 1, 0);
    chk("d2_ovf", {63'd0, bus.ovf}, 64'd1);
`ifdef RCA_PIPE_SAT_EN
    chk("d2_sum", {32'd0, bus.sum}, 64'h7FFF_FFFF);
`else
    chk("d2_sum", {32'd0, bus.sum}, 64'h8000_0000);
`endif
    cycle(0, 0, 0, 0, 1, 0);
    chk("d3_cout", {63'd0, bus.cout}, 64'd1);
`ifdef RCA_PIPE_SAT_EN
    chk("d3_sum", {32'd0, bus.sum}, 64'h8000_0000);
`else
    chk("d3_sum", {32'd0, bus.sum}, 64'h7FFF_FFFF);
`endif
    repeat (4) cycle(0, 0, 0, 0, 1, 0);

    // 16 back-to-back operations.
    run_max = 0;
    repeat (16) cycle(1, rnd_word(), rnd_word(), 1'($urandom), 1, 0);
    repeat (6) cycle(0, 0, 0, 0, 1, 0);
    chk("b2b_run", 64'(run_max), 64'd16);

    // Fill pipe, stall 3 cycles with an operand presented, then release.
    repeat (4) cycle(1, rnd_word(), rnd_word(), 1'($urandom), 1, 0);
    xa = rnd_word();
    xb = rnd_word();
    xc = 1'($urandom);
    repeat (3) cycle(1, xa, xb, xc, 0, 0);
    base = n_ret;
    cycle(1, xa, xb, xc, 1, 0);
    repeat (6) cycle(0, 0, 0, 0, 1, 0);
    chk("stall_drain", 64'(n_ret - base), 64'd5);

    // Random valid/ready traffic.
    repeat (400) cycle($urandom_range(0, 3) != 0, rnd_word(), rnd_word(), 1'($urandom),
                       $urandom_range(0, 3) != 0, 0);
    repeat (8) cycle(0, 0, 0, 0, 1, 0);

    // Reset with three operations in flight.
    repeat (3) cycle(1, rnd_word(), rnd_word(), 1'($urandom), 1, 0);
    cycle(0, 0, 0, 0, 0, 1);
    chk("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("mid_rst_sum", {32'd0, bus.sum}, 64'd0);
    chk("mid_rst_cout", {63'd0, bus.cout}, 64'd0);
    chk("mid_rst_ovf", {63'd0, bus.ovf}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    stale = 0;
    repeat (6) begin
      cycle(0, 0, 0, 0, 1, 0);
      if (bus.out_valid) stale++;
    end
    chk("no_stale", 64'(stale), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
